// File: rtl/mem_burst_ctl.sv
// mem_burst_ctl: burst read/write initiator for a single-port block RAM; define MEM_BURST_CSUM_EN to add the csum output.
module mem_burst_ctl #(
  parameter int WIDTH = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     op_write,
  input  logic [RAM_ADDR_BITS-1:0] base_adr,
  input  logic [RAM_ADDR_BITS:0]   len,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     mem_en,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
`ifdef MEM_BURST_CSUM_EN
  ,
  output logic [WIDTH-1:0]         csum
`endif
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, RD_OUT, WR, DONE} state_t;
  localparam logic [RAM_ADDR_BITS-1:0] adr_one = 1;
  localparam logic [RAM_ADDR_BITS:0] rem_one = 1;
  state_t state, next;
  logic [RAM_ADDR_BITS-1:0] cur_adr;
  logic [RAM_ADDR_BITS:0] remaining;
  logic accept, hs, last;
  assign last = remaining == rem_one;
  always_comb begin
    next = state;
    accept = 1'b0;
    hs = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        next = !start ? IDLE : (len == '0) ? DONE : op_write ? WR : RD_ISSUE;
      end
      RD_ISSUE: next = RD_CAP;
      RD_CAP: next = RD_OUT;
      RD_OUT: begin
        hs = out_ready;
        next = !out_ready ? RD_OUT : last ? DONE : RD_ISSUE;
      end
      WR: begin
        hs = in_valid;
        next = (in_valid && last) ? DONE : WR;
      end
      default: next = IDLE;
    endcase
  end
  assign done      = state == DONE;
  assign in_ready  = state == WR;
  assign out_valid = state == RD_OUT;
  assign mem_write = (state == WR) && in_valid;
  assign mem_en    = mem_write || (state == RD_ISSUE);
  assign mem_adr   = mem_en ? cur_adr : '0;
  assign mem_wdata = mem_write ? in_data : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  // cur_adr wraps naturally at the RAM depth; a bump after the last read is harmless since IDLE reloads it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur_adr   <= '0;
      remaining <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        cur_adr   <= base_adr;
        remaining <= len;
      end else if (hs) begin
        cur_adr   <= cur_adr + adr_one;
        remaining <= remaining - rem_one;
      end
      if (state == RD_CAP) out_data <= mem_rdata;
      busy <= next != IDLE;
    end
`ifdef MEM_BURST_CSUM_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) csum <= '0;
    else if (accept) csum <= '0;
    else if (hs) csum <= csum + ((state == WR) ? in_data : out_data);
`endif
endmodule
